// File: rtl/fft_bitrev_reorder.sv
// Purpose: reorders bit-reversed FFT output frames (N = 2**LOG2N) into natural order using ping-pong banks.
// Latency: first output two cycles after the sample that completes a frame; 32 contiguous output cycles.
// Backpressure: none; the writer needs >= N cycles per bank and the reader exactly N, so banks never overflow.
module fft_bitrev_reorder #(
  parameter int DW    = 22,
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    data_in_real,
  input  logic [DW-1:0]    data_in_imag,
  output logic             out_valid,
  output logic [DW-1:0]    data_out_real,
  output logic [DW-1:0]    data_out_imag,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_ADDR = '1;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_READ = 1'b1;

  // Two banks side by side; the bank select is the top address bit.
  logic [2*DW-1:0]  mem [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic             state;
  logic [LOG2N-1:0] rd_addr;
  logic             rd_bank;

  logic             wr_wrap;
  logic             rd_active;
  logic             rd_done;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Read issue is combinational on full so the first output lands two cycles after the last sample.
  always_comb begin
    wr_wrap   = in_valid && (wr_cnt == LAST_ADDR);
    rd_active = (state == S_READ) || full[rd_bank];
    rd_done   = rd_active && (rd_addr == LAST_ADDR);
    full_nxt  = full;
    if (rd_done) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (wr_wrap) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Sample storage at the bit-reversed address; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      mem[{wr_bank, bitrev(wr_cnt)}] <= {data_in_real, data_in_imag};
    end
  end

  // Writer counter and bank select; reset wins over a sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_wrap) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank-full flags: set by the writer on wrap, cleared by the reader after its last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      full <= full_nxt;
    end
  end

  // Reader FSM: sweeps a full bank once, chaining straight into the other bank if it is already full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else if (rd_active) begin
      if (rd_done) begin
        rd_addr <= '0;
        rd_bank <= ~rd_bank;
        state   <= full_nxt[~rd_bank] ? S_READ : S_IDLE;
      end else begin
        rd_addr <= rd_addr + 1'b1;
        state   <= S_READ;
      end
    end
  end

  // Output register; everything is forced to zero when no read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_index     <= '0;
      data_out_real <= '0;
      data_out_imag <= '0;
    end else begin
      out_valid <= rd_active;
      out_last  <= rd_done;
      out_index <= rd_active ? rd_addr : '0;
      {data_out_real, data_out_imag} <= rd_active ? mem[{rd_bank, rd_addr}] : '0;
    end
  end

  assign busy = full[0] | full[1] | (state == S_READ) | out_valid;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Purpose: randomized scoreboard bench for fft_bitrev_reorder against a frame-level reorder model.
// Latency: expected output cycle = capture edge of last sample + 1 + bin index.
// Backpressure: none on the DUT; the bench only drives and observes.
module tb_fft_bitrev_reorder;

  localparam int DW    = 22;
  localparam int LOG2N = 5;
  localparam int N     = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [DW-1:0]    data_in_real;
  logic [DW-1:0]    data_in_imag;
  logic             out_valid;
  logic [DW-1:0]    data_out_real;
  logic [DW-1:0]    data_out_imag;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             busy;

  fft_bitrev_reorder #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in_real (data_in_real),
    .data_in_imag (data_in_imag),
    .out_valid    (out_valid),
    .data_out_real(data_out_real),
    .data_out_imag(data_out_imag),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy)
  );

  typedef struct {
    int          idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int          edge_no;
  } exp_t;

  exp_t          exp_q[$];
  logic [2*DW-1:0] fbuf [0:N-1];
  int            mcnt = 0;
  int            edge_cnt = 0;
  int            checks = 0;
  int            failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      if ((k >> i) & 1) r += 1 << (LOG2N - 1 - i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference model: the k-th accepted sample of a frame belongs to natural bin brev(k).
  task automatic model_push(input logic [DW-1:0] re, input logic [DW-1:0] im, input int cap);
    exp_t e;
    fbuf[brev(mcnt)] = {re, im};
    mcnt++;
    if (mcnt == N) begin
      for (int i = 0; i < N; i++) begin
        e.idx     = i;
        e.re      = fbuf[i][2*DW-1:DW];
        e.im      = fbuf[i][DW-1:0];
        e.edge_no = cap + 1 + i;
        exp_q.push_back(e);
      end
      mcnt = 0;
    end
  endtask

  task automatic do_set(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im, input logic r);
    rst          = r;
    in_valid     = v;
    data_in_real = re;
    data_in_imag = im;
    if (r) begin
      exp_q.delete();
      mcnt = 0;
    end else if (v) begin
      model_push(re, im, edge_cnt + 1);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im, input logic r);
    @(negedge clk);
    do_set(v, re, im, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic rand_frame();
    for (int k = 0; k < N; k++) drive(1'b1, rnd(), rnd(), 1'b0);
  endtask

  // Monitor: pops one expectation per valid output and checks data, index, last flag and cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=index %0d re %0h expected=no output", out_index, data_out_real);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'({out_index, data_out_real, data_out_imag, out_last}),
              64'({e.idx[LOG2N-1:0], e.re, e.im, (e.idx == N - 1)}));
          chk("out_cycle", 64'(edge_cnt), 64'(e.edge_no));
        end
      end else begin
        chk("idle_zero", 64'({out_index, data_out_real, data_out_imag, out_last}), 64'(0));
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1; in_valid = 1'b0; data_in_real = '0; data_in_imag = '0;
    // Reset and a sample in the very first cycle: the sample must be dropped.
    do_set(1'b1, DW'(777), DW'(555), 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outputs", 64'({out_index, data_out_real, data_out_imag, out_last}), 64'(0));
    do_set(1'b0, '0, '0, 1'b0);

    // Single frame: sample k carries (brev(k), -brev(k)), so bin i reads back (i, -i).
    for (int k = 0; k < N; k++) drive(1'b1, DW'(brev(k)), DW'(-brev(k)), 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    chk("busy_after_frame", 64'(busy), 64'(1));
    idle(40);

    // Three back-to-back frames, offset by 100 per frame.
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) drive(1'b1, DW'(brev(k) + 100 * f), rnd(), 1'b0);
    idle(40);

    // Gapped frame with full-scale values.
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(2))
        0: drive(1'b1, DW'(2097151), DW'(-2097152), 1'b0);
        1: drive(1'b1, DW'(-2097152), DW'(2097151), 1'b0);
        default: drive(1'b1, rnd(), rnd(), 1'b0);
      endcase
      drive(1'b0, rnd(), rnd(), 1'b0);
    end
    idle(40);

    // Reset mid-frame after 17 samples, then one clean frame.
    for (int k = 0; k < 17; k++) drive(1'b1, rnd(), rnd(), 1'b0);
    drive(1'b1, rnd(), rnd(), 1'b1);
    rand_frame();
    idle(40);

    // Reset while bin 10 is being presented.
    rand_frame();
    drive(1'b0, '0, '0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_index == 10) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      do_set(1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk("rdrst_out_valid", 64'(out_valid), 64'(0));
      chk("rdrst_busy", 64'(busy), 64'(0));
      do_set(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("rdrst_stays_low", 64'(out_valid), 64'(0));
    end else begin
      checks++;
      failures++;
      $display("FAIL rdrst_wait actual=no index 10 expected=index 10 within 100 cycles");
    end
    idle(5);
    rand_frame();
    idle(40);

    // Partial frame is held indefinitely, then completed.
    for (int k = 0; k < 10; k++) drive(1'b1, rnd(), rnd(), 1'b0);
    idle(50);
    chk("partial_busy", 64'(busy), 64'(0));
    for (int k = 10; k < N; k++) drive(1'b1, rnd(), rnd(), 1'b0);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    chk("drain", 64'(exp_q.size()), 64'(0));
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter DW, 22, signed sample width of each real/imag component.
REQ-002 Parameter LOG2N, 5, log2 of the frame length (N = 32); fixed at 5 for this FFT.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  the input sample is present this cycle; gaps within a frame are allowed.
REQ-006 Port data_in_real / data_in_imag  input  DW each  FFT-stage output sample, in bit-reversed order.
REQ-007 Port out_valid  output  1  data_out_* and out_index are valid this cycle.
REQ-008 Port data_out_real / data_out_imag  output  DW each  sample in natural frequency order.
REQ-009 Port out_index  output  LOG2N  frequency bin of the current output, 0..31.
REQ-010 Port out_last  output  1  high with the output where out_index == 31.
REQ-011 Port busy  output  1  high while a full bank is pending or is being read.

Function
REQ-012 Storage shall be two banks (ping-pong), each of 32 x 2*DW bits; bank contents are not reset.
REQ-013 Writer: wr_cnt (5 bit) and wr_bank (1 bit); each in_valid cycle writes bank[wr_bank][bitrev5(wr_cnt)] and increments wr_cnt.
REQ-014 bitrev5 maps address bits b4..b0 to b0..b4; for example, wr_cnt 1 goes to address 16 and wr_cnt 3 goes to address 24.
REQ-015 When wr_cnt wraps from 31 to 0, the module shall set full[wr_bank] and toggle wr_bank, both at the same clock edge.
REQ-016 Reader FSM states are IDLE and READ; rd_addr is 5 bit and rd_bank is 1 bit.
REQ-017 IDLE -> READ occurs when full[rd_bank] is 1; rd_addr starts at 0.
REQ-018 In READ, rd_addr increments once per cycle with no stall.
REQ-019 At rd_addr == 31, the reader shall clear full[rd_bank] and toggle rd_bank.
  - It then goes to READ with rd_addr = 0 if full of the new bank is 1 (including a full bit set at that same edge).
  - Otherwise it goes to IDLE.
REQ-020 data_out_*, out_index, out_valid and out_last shall be registered one cycle after the read address is issued.
REQ-021 Latency: for a 32nd in_valid in cycle T, out_valid shall be high in cycles T+2 through T+33 with out_index 0..31.
REQ-022 Output shall be contiguous: out_valid never drops within a frame.
REQ-023 Frames completed back-to-back shall produce gap-free output.
REQ-024 Overflow cannot occur: the writer needs at least 32 cycles per bank and the reader exactly 32; no overflow flag is provided.
REQ-025 When out_valid is 0, data_out_*, out_index and out_last shall be driven to 0.
REQ-026 busy = full[0] | full[1] | (state == READ) | out_valid.
REQ-027 A partial frame (wr_cnt != 0) shall be held indefinitely while in_valid is low; there is no timeout.
REQ-028 Arithmetic: data shall be passed bit-exact, with no scaling, rounding or sign change.

Reset
REQ-029 On rst = 1 at a clock edge, the following shall clear:
  - wr_cnt = 0, wr_bank = 0
  - full = 2'b00, rd_bank = 0, rd_addr = 0, state = IDLE
  - out_valid = 0, out_last = 0, out_index = 0, data_out_* = 0
REQ-030 rst shall take priority over in_valid in the same cycle; that sample shall be discarded.
REQ-031 Reset mid-frame or mid-read shall discard all partial and pending frames.
  - Output shall be low from the cycle after reset.
  - The next accepted sample shall be sample 0 of bank 0.

Verification
REQ-032 Single frame: drive 32 contiguous samples in bit-reversed order, sample k = (bitrev5(k), -bitrev5(k)) -> out_index 0..31 carries real = index, imag = -index; out_valid in T+2..T+33; out_last only at index 31.
REQ-033 Back-to-back: drive 96 contiguous samples (3 frames with values offset by +100 per frame) -> 96 consecutive out_valid cycles in natural order, no gap between frames.
REQ-034 Gapped input: in_valid toggles 1-0-1-0 over one frame -> output is still 32 contiguous cycles starting 2 cycles after the last sample; full-scale values +2^21-1 and -2^21 pass unchanged.
REQ-035 Reset mid-frame: apply rst after 17 samples, then send one full frame -> exactly 32 outputs, all from the new frame.
REQ-036 Reset during read: apply rst at out_index 10 -> out_valid is 0 from the next cycle, busy is 0, and no stale data appears after a later frame.
REQ-037 Simultaneous rst and in_valid on cycle 0 -> the sample is ignored and wr_cnt stays at 0.
